pixel_frame_reader: RTL and testbench
=====================================

# pixel_frame_reader

Avalon-MM read master that fetches a frame of pixel words from the on-chip RAM and presents them as a ready/valid pixel stream to the LED serializer. Software programs a start word address and a word count, then pulses `start`. The block issues pipelined reads, buffers returned data in a small FIFO, and strips each 32-bit word to a 24-bit GRB pixel. It sits between the RAM's slave port and the pixel output shifter.

## Interface
- `ADDR_W`, 11: word-address width of the RAM port.
- `FIFO_DEPTH`, 4: pixel buffer entries, power of two, ≥2.
- `CNT_W`, 12: width of the word-count input.

- `clk` in 1: single clock for the entire block.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a frame; only honoured while idle.
- `base_address` in ADDR_W: first word address; sampled on `start`.
- `word_count` in CNT_W: number of words to read; sampled on `start`.
- `avm_address` out ADDR_W: word address of the current read.
- `avm_read` out 1: read request.
- `avm_waitrequest` in 1: slave stall; the request is held while high.
- `avm_readdata` in 32: read data.
- `avm_readdatavalid` in 1: read data valid, returned in request order.
- `pixel_data` out 24: `readdata[23:0]` of the FIFO head.
- `pixel_valid` out 1: FIFO non-empty.
- `pixel_ready` in 1: consumer accepts the head when high together with `pixel_valid`.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse when the final pixel is accepted.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `base_address` into the address register and `word_count` into the issue and retire counters.
  - If count ≠ 0, go to RUN. If count = 0, go directly to DONE.
- RUN: issue a read whenever all of the following hold:
  - `avm_read` is not already pending.
  - Issue counter ≠ 0.
  - FIFO occupancy + outstanding reads < FIFO_DEPTH. This credit rule guarantees the FIFO never overflows.
- Accepted read (`avm_read`=1 and `avm_waitrequest`=0):
  - Address increments by 1, wrapping modulo 2^ADDR_W.
  - Issue counter decrements.
  - Outstanding count increments.
  - When the issue counter reaches 0, go to DRAIN.
- While `avm_waitrequest`=1: `avm_read` and `avm_address` are held stable.
- `avm_readdatavalid`=1: push `readdata[23:0]` into the FIFO and decrement the outstanding count. An accept and a return in the same cycle leave the outstanding count unchanged.
- Pixel handshake (`pixel_valid` & `pixel_ready`): pop the FIFO and decrement the retire counter. A simultaneous push and pop leave occupancy unchanged.
- DRAIN: no new reads. When the retire counter reaches 0, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in RUN, DRAIN, and DONE.
- `start` while not IDLE: ignored, with no effect on counters or address.
- `avm_readdatavalid` with outstanding = 0 is a protocol error. It is ignored and no FIFO push occurs.
- `reset_n` low at any time, including mid-frame:
  - All state is cleared and the FIFO is emptied.
  - Outstanding reads are forgotten. Any data returned after release is dropped by the rule above.

## Timing
- Reset values:
  - `avm_read`=0, `avm_address`=0.
  - `pixel_valid`=0, `pixel_data`=0.
  - `busy`=0, `done`=0.
  - State IDLE, FIFO empty, all counters 0.
- `start` at cycle N: `busy`=1 and `avm_read`=1 with `avm_address`=`base_address` at N+1.
- All outputs are registered except `pixel_data` and `pixel_valid`, which come from the FIFO head register and carry no combinational path from `pixel_ready`.
- Returned data at cycle M gives `pixel_valid`=1 at M+1.
- Throughput with zero waitrequest, 1-cycle read latency and `pixel_ready` held high: one pixel per cycle after the initial fill.
- Count = 0: `done` pulses at N+1, `busy`=1 only in that cycle, and no read is issued.
- `done` is asserted the cycle after the final pop; the block returns to IDLE the following cycle and accepts a new `start` from then on.

## Test plan
- Basic frame: RAM words 0x00AABBCC, 0x00112233, 0x00445566 at addresses 0x10–0x12; base=0x10, count=3, `pixel_ready`=1 → pixels 0xAABBCC, 0x112233, 0x445566 in order, one `done` pulse, exactly 3 reads issued.
- Wrap-around: base=0x7FE, count=4 → read addresses 0x7FE, 0x7FF, 0x000, 0x001.
- Backpressure: count=10, `pixel_ready`=0 for 20 cycles → at most 4 reads issued and never more than 4 in the FIFO; after release, all 10 pixels arrive intact.
- Waitrequest: `avm_waitrequest` high for 3 cycles on the 2nd read → `avm_read` and `avm_address` stable throughout; the output sequence is unchanged.
- Edge controls: count=0 gives `done` one cycle after `start` with no reads; a `start` pulse mid-frame is ignored.
- Mid-frame reset: assert `reset_n` low after 2 of 8 pixels → all outputs return to reset values; a fresh frame then completes correctly.

Source files
------------

// File: rtl/pixel_frame_reader.sv
// pixel_frame_reader: Avalon-MM read master that fetches a frame of 32-bit
// words and presents their low 24 bits as a ready/valid GRB pixel stream.
module pixel_frame_reader #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_address,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [23:0]       pixel_data,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned OW = PW + 1;
  localparam logic [OW:0] DEPTH_C = (OW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  issue_q, issue_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              read_q, read_d;
  logic              busy_q, done_q;
  logic [23:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;

  logic accept, push, pop, credit;

  assign accept = read_q & ~avm_waitrequest;
  // Returns with nothing outstanding (e.g. stale data after reset) are dropped.
  assign push   = avm_readdatavalid & (outst_q != '0);
  assign pop    = (occ_q != '0) & pixel_ready;

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pixel_valid = (occ_q != '0);
  assign pixel_data  = mem_q[rd_ptr_q];

  // Next-state, counters and read-issue decision.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    issue_d  = issue_q;
    retire_d = retire_q;
    read_d   = 1'b0;
    occ_d    = occ_q + OW'(push) - OW'(pop);
    outst_d  = outst_q + OW'(accept) - OW'(push);
    if (accept) begin
      addr_d  = addr_q + ADDR_W'(1);
      issue_d = issue_q - CNT_W'(1);
    end
    if (pop && (retire_q != '0)) retire_d = retire_q - CNT_W'(1);
    // Credit uses post-edge occupancy/outstanding so a new request can follow
    // an accepted one back to back without ever overfilling the FIFO.
    credit = ({1'b0, occ_d} + {1'b0, outst_d}) < DEPTH_C;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = base_address;
          issue_d  = word_count;
          retire_d = word_count;
          if (word_count != '0) begin
            state_d = S_RUN;
            read_d  = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (read_q && avm_waitrequest) read_d = 1'b1;
        else if ((issue_d != '0) && credit) read_d = 1'b1;
        if (issue_d == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (retire_d == '0) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      issue_q  <= '0;
      retire_q <= '0;
      outst_q  <= '0;
      occ_q    <= '0;
      read_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      issue_q  <= issue_d;
      retire_q <= retire_d;
      outst_q  <= outst_d;
      occ_q    <= occ_d;
      read_q   <= read_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
    end
  end

  // Pixel FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= avm_readdata[23:0];
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

endmodule

// File: tb/tb_pixel_frame_reader.sv
// Directed bench for pixel_frame_reader with a 1-cycle-latency RAM model and
// address/pixel scoreboards.
module tb_pixel_frame_reader;

  localparam int AW = 11;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset_n, start, pixel_ready;
  logic [AW-1:0] base_address, avm_address;
  logic [CW-1:0] word_count;
  logic          avm_read, avm_waitrequest, avm_readdatavalid;
  logic [31:0]   avm_readdata;
  logic [23:0]   pixel_data;
  logic          pixel_valid, busy, done;

  always #5 clk = ~clk;

  pixel_frame_reader #(.ADDR_W(AW), .FIFO_DEPTH(4), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base_address(base_address), .word_count(word_count),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .busy(busy), .done(done)
  );

  int total = 0, bad = 0;
  int reads = 0, pops = 0, dones = 0, stalls = 0;
  int stall_at = -1, wait_cycles = 0, acc_n = 0;
  logic          mon_en = 1'b0;
  logic          inj_rdv = 1'b0;
  logic          slv_rdv = 1'b0;
  logic [31:0]   slv_data = '0;
  logic          prev_wait = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   ram [0:2047];
  logic [23:0]   exp_px [$];
  logic [AW-1:0] exp_addr [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RAM slave: stalls the read numbered stall_at for 3 cycles, data 1 cycle after accept.
  assign avm_waitrequest   = avm_read && (acc_n == stall_at) && (wait_cycles < 3);
  assign avm_readdatavalid = slv_rdv | inj_rdv;
  assign avm_readdata      = slv_rdv ? slv_data : 32'hA5FF_EEDD;

  always @(posedge clk) begin
    slv_rdv     <= avm_read && !avm_waitrequest;
    slv_data    <= ram[avm_address];
    if (avm_read && !avm_waitrequest) acc_n <= acc_n + 1;
    wait_cycles <= (avm_read && avm_waitrequest) ? wait_cycles + 1 : 0;
  end

  // Monitor: read addresses, request hold under stall, pixel order, credit bound.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (prev_wait) begin
        check("hold_read", avm_read, 1'b1);
        check("hold_addr", avm_address, prev_addr);
      end
      prev_wait = avm_read && avm_waitrequest;
      prev_addr = avm_address;
      if (avm_read && avm_waitrequest) stalls++;
      if (avm_read && !avm_waitrequest) begin
        reads++;
        check("read_expected", exp_addr.size() != 0, 1'b1);
        if (exp_addr.size() != 0) check("read_addr", avm_address, exp_addr.pop_front());
      end
      if (pixel_valid && pixel_ready) begin
        pops++;
        check("pixel_expected", exp_px.size() != 0, 1'b1);
        if (exp_px.size() != 0) check("pixel_data", pixel_data, exp_px.pop_front());
      end
      if (busy) check("credit_bound", (reads - pops) <= 4, 1'b1);
      if (done) dones++;
    end
  end

  task automatic push_frame(input logic [AW-1:0] b, input int c);
    logic [AW-1:0] a;
    for (int i = 0; i < c; i++) begin
      a = b + AW'(i);
      exp_addr.push_back(a);
      exp_px.push_back(ram[a][23:0]);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [CW-1:0] c);
    @(posedge clk); #1;
    base_address = b; word_count = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_address = '0; word_count = '0;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input int c);
    reads = 0; pops = 0;
    push_frame(b, c);
    pulse_start(b, CW'(c));
    @(negedge clk);
    check("busy_after_start", busy, 1'b1);
    check("read_after_start", avm_read, c != 0);
    check("done_after_start", done, c == 0);
    if (c != 0) check("addr_after_start", avm_address, b);
  endtask

  task automatic wait_done(input int budget, output int n);
    int d0;
    d0 = dones;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
    check("busy_at_done", busy, 1'b1);
    check("pixels_left", exp_px.size(), 0);
    check("reads_left", exp_addr.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
    check("done_count", dones - d0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read"}, avm_read, 1'b0);
    check({tag, "_addr"}, avm_address, '0);
    check({tag, "_valid"}, pixel_valid, 1'b0);
    check({tag, "_pdata"}, pixel_data, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 2048; i++) ram[i] = {8'hA5, 24'(i * 24'h010203) ^ 24'h5A5A5A};
    ram[16] = 32'h00AABBCC; ram[17] = 32'h00112233; ram[18] = 32'h00445566;
    reset_n = 1'b0; start = 1'b0; base_address = '0; word_count = '0; pixel_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 reset_n = 1'b1;
    mon_en = 1'b1;

    // Basic 3-word frame.
    do_start(11'h010, 3);
    wait_done(50, n);
    check("basic_reads", reads, 3);

    // Full-rate throughput with ready held high.
    do_start(11'h080, 8);
    wait_done(50, n);
    check("throughput_cycles", n, 10);

    // Address wrap.
    do_start(11'h7FE, 4);
    wait_done(50, n);
    check("wrap_reads", reads, 4);

    // Backpressure.
    pixel_ready = 1'b0;
    do_start(11'h100, 10);
    repeat (20) @(negedge clk);
    check("bp_reads_bounded", reads <= 4, 1'b1);
    check("bp_valid", pixel_valid, 1'b1);
    check("bp_busy", busy, 1'b1);
    @(posedge clk); #1 pixel_ready = 1'b1;
    wait_done(100, n);
    check("bp_reads", reads, 10);

    // Waitrequest on the 2nd read.
    stalls = 0;
    stall_at = acc_n + 1;
    do_start(11'h020, 6);
    wait_done(60, n);
    stall_at = -1;
    check("stall_cycles", stalls, 3);

    // Count of zero: immediate done, no reads.
    do_start(11'h030, 0);
    @(negedge clk);
    check("zero_done_once", done, 1'b0);
    check("zero_busy_once", busy, 1'b0);
    check("zero_reads", reads, 0);

    // Start while busy is ignored.
    pixel_ready = 1'b0;
    do_start(11'h040, 6);
    pulse_start(11'h200, 12'd3);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 pixel_ready = 1'b1;
    wait_done(80, n);
    check("ignored_start_reads", reads, 6);

    // Mid-frame reset after 2 pixels, then stray return, then fresh frame.
    do_start(11'h050, 8);
    n = 0;
    while (pops < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("two_pixels_seen", pops >= 2, 1'b1);
    @(posedge clk); #1 reset_n = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_px.delete(); exp_addr.delete();
    prev_wait = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1 inj_rdv = 1'b1;
    @(posedge clk); #1 inj_rdv = 1'b0;
    @(negedge clk);
    check("stray_dropped", pixel_valid, 1'b0);
    check("stray_idle", busy, 1'b0);
    do_start(11'h060, 5);
    wait_done(50, n);
    check("fresh_reads", reads, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
